// File: rtl/fp_drv_pkg.sv
// Shared types and helpers for the FP polynomial stream driver.
package fp_drv_pkg;

    localparam int FLEN_DEF = 64;

    typedef struct packed {
        logic [FLEN_DEF-1:0] a;
        logic [FLEN_DEF-1:0] b;
        logic [FLEN_DEF-1:0] c;
    } fp_triple_t;

    // Occupancy counters need one extra bit to represent a completely full FIFO.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fp_drv_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; head is presented combinationally on dout.
module fp_drv_sync_fifo
    import fp_drv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fp_poly_stream_driver.sv
// Credit-gated issue/retire wrapper around the non-stallable a**5 + 0.3*b + c pipeline.
// Optional issue/retire counters are compiled in with FP_DRV_STATS_EN.
module fp_poly_stream_driver
    import fp_drv_pkg::*;
#(
    parameter int FLEN      = FLEN_DEF,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [FLEN-1:0] in_a,
    input  logic [FLEN-1:0] in_b,
    input  logic [FLEN-1:0] in_c,
    output logic            arg_vld,
    output logic [FLEN-1:0] arg_a,
    output logic [FLEN-1:0] arg_b,
    output logic [FLEN-1:0] arg_c,
    input  logic            res_vld,
    input  logic [FLEN-1:0] res,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [FLEN-1:0] out_data,
    output logic            busy,
    output logic            err_ovf
`ifdef FP_DRV_STATS_EN
    ,
    output logic [31:0]     issued_cnt,
    output logic [31:0]     retired_cnt
`endif
);
    localparam int ICW = cnt_w(IN_DEPTH);
    localparam int OCW = cnt_w(OUT_DEPTH);
    localparam logic [OCW-1:0] OUT_CAP = OCW'(OUT_DEPTH);

    logic              in_full;
    logic              in_empty;
    logic              in_push;
    logic [ICW-1:0]    in_count;
    logic [3*FLEN-1:0] in_head;
    logic              out_full;
    logic              out_empty;
    logic              out_pop;
    logic [OCW-1:0]    out_count;
    logic [OCW-1:0]    inflight;
    logic [OCW-1:0]    credit;
    logic              issue;
    logic              res_ok;

    assign in_rdy  = !rst && !in_full;
    assign in_push = in_vld && in_rdy;

    fp_drv_sync_fifo #(.WIDTH(3*FLEN), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .push(in_push), .pop(issue), .din({in_a, in_b, in_c}),
        .dout(in_head), .full(in_full), .empty(in_empty), .count(in_count)
    );

    assign out_vld = !out_empty;
    assign out_pop = out_vld && out_rdy;

    // Every issued triple reserves a result slot, so out_count + inflight never exceeds OUT_DEPTH.
    assign credit = OUT_CAP - out_count - inflight;
    assign issue  = !in_empty && (credit != '0);
    assign res_ok = res_vld && (inflight != '0) && (!out_full || out_pop);

    fp_drv_sync_fifo #(.WIDTH(FLEN), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk), .rst(rst), .push(res_ok), .pop(out_pop), .din(res),
        .dout(out_data), .full(out_full), .empty(out_empty), .count(out_count)
    );

    assign busy = (in_count != '0) || (inflight != '0) || !out_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            arg_vld  <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            case ({issue, res_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            arg_vld <= issue;
            if (res_vld && !res_ok) err_ovf <= 1'b1;
        end
    end

    // issue stage: operand FIFO head -> registered pipeline arguments
    always_ff @(posedge clk) begin
        if (rst) begin
            {arg_a, arg_b, arg_c} <= '0;
        end else if (issue) begin
            {arg_a, arg_b, arg_c} <= in_head;
        end
    end

`ifdef FP_DRV_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt  <= '0;
            retired_cnt <= '0;
        end else begin
            if (arg_vld) issued_cnt  <= issued_cnt + 32'd1;
            if (out_pop) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_poly_stream_driver.sv
// Bench for fp_poly_stream_driver: fixed-latency pipeline model, ordered scoreboard, directed + random traffic.
module tb_fp_poly_stream_driver;

    localparam int L         = 10;
    localparam int OUT_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b1;
    logic        force_res = 1'b0;
    logic [63:0] in_a = '0, in_b = '0, in_c = '0, force_val = '0;
    logic        in_rdy, arg_vld, out_vld, busy, err_ovf, res_vld;
    logic [63:0] arg_a, arg_b, arg_c, res, out_data;
`ifdef FP_DRV_STATS_EN
    logic [31:0] issued_cnt, retired_cnt;
`endif

    always #5 clk = ~clk;

    fp_poly_stream_driver dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .arg_vld(arg_vld), .arg_a(arg_a), .arg_b(arg_b), .arg_c(arg_c),
        .res_vld(res_vld), .res(res),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .busy(busy), .err_ovf(err_ovf)
`ifdef FP_DRV_STATS_EN
        , .issued_cnt(issued_cnt), .retired_cnt(retired_cnt)
`endif
    );

    function automatic logic [63:0] poly(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        real ra, rb, rc;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        rc = $bitstoreal(c);
        return $realtobits(ra * ra * ra * ra * ra + 0.3 * rb + rc);
    endfunction

    function automatic logic [63:0] rnd_fp();
        return $realtobits(real'(int'($urandom_range(0, 4000)) - 2000) / 1000.0);
    endfunction

    // In-order pipeline of fixed latency L sharing rst with the driver.
    logic        pv [L];
    logic [63:0] pd [L];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= arg_vld;
            pd[0] <= poly(arg_a, arg_b, arg_c);
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign res_vld = pv[L-1] | force_res;
    assign res     = force_res ? force_val : pd[L-1];

    int tot = 0, bad = 0;
    int acc = 0, ret = 0, iss = 0, run = 0, max_run = 0;
    bit exp_err = 1'b0, mon_en = 1'b0;
    logic [191:0] tq[$];
    logic [63:0]  rq[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every triple accepted is issued and retired exactly once, in order.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("err_ovf", err_ovf, exp_err);
            chk("busy", busy, acc != ret);
            chk("credit_bound", (iss - ret) <= OUT_DEPTH, 1'b1);
            if (rst) chk("in_rdy_in_rst", in_rdy, 1'b0);
`ifdef FP_DRV_STATS_EN
            chk("issued_cnt", issued_cnt, iss);
            chk("retired_cnt", retired_cnt, ret);
`endif
            if (arg_vld) begin
                if (tq.size() == 0) chk("arg_unexpected", arg_vld, 1'b0);
                else chk("arg_triple", {arg_a, arg_b, arg_c}, tq.pop_front());
                iss++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (!rst && out_vld && out_rdy) begin
                if (rq.size() == 0) chk("out_unexpected", out_vld, 1'b0);
                else chk("out_data", out_data, rq.pop_front());
                ret++;
            end
            if (!rst && in_vld && in_rdy) begin
                tq.push_back({in_a, in_b, in_c});
                rq.push_back(poly(in_a, in_b, in_c));
                acc++;
            end
            if (force_res) exp_err = 1'b1;
            if (rst) begin
                tq.delete();
                rq.delete();
                acc = 0; ret = 0; iss = 0; run = 0;
                exp_err = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int max_cyc);
        int sent = 0;
        int cyc = 0;
        bit took;
        in_a = rnd_fp(); in_b = rnd_fp(); in_c = rnd_fp();
        in_vld = 1'b1;
        while (sent < n && cyc < max_cyc) begin
            @(negedge clk);
            took = in_rdy;
            if (took) sent++;
            tick();
            cyc++;
            if (took) begin
                in_a = rnd_fp(); in_b = rnd_fp(); in_c = rnd_fp();
            end
            if (sent >= n) in_vld = 1'b0;
        end
        in_vld = 1'b0;
        chk("send_count", sent, n);
    endtask

    task automatic wait_idle(input int max_cyc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < max_cyc);
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int iss0;
        // reset held for three edges
        tick();
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_arg_vld", arg_vld, 1'b0);
            chk("rst_out_vld", out_vld, 1'b0);
            chk("rst_in_rdy", in_rdy, 1'b0);
            chk("rst_busy", busy, 1'b0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("in_rdy_after_rst", in_rdy, 1'b1);

        // single triple 1.0, 0, 0
        tick();
        in_a = 64'h3FF0000000000000; in_b = '0; in_c = '0; in_vld = 1'b1;
        @(negedge clk);
        chk("t2_accept", in_rdy, 1'b1);
        tick();
        in_vld = 1'b0;
        @(negedge clk);
        chk("t2_arg_vld_early", arg_vld, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_arg_vld", arg_vld, 1'b1);
        chk("t2_arg_a", arg_a, 64'h3FF0000000000000);
        for (int i = 0; i < 40 && !out_vld; i++) @(negedge clk);
        chk("t2_out_vld", out_vld, 1'b1);
        chk("t2_out_data", out_data, 64'h3FF0000000000000);
        @(negedge clk);
        chk("t2_busy_after_pop", busy, 1'b0);

        // 32 back-to-back triples
        tick();
        max_run = 0;
        send(32, 200);
        wait_idle(200);
        chk("t3_issue_run", max_run, 32);
        chk("t3_err_ovf", err_ovf, 1'b0);

        // stalled output: credit limits issue to OUT_DEPTH
        tick();
        out_rdy = 1'b0;
        iss0 = iss;
        send(20, 100);
        repeat (30) @(negedge clk);
        chk("t4_issued_stalled", iss - iss0, 16);
        chk("t4_in_rdy_full", in_rdy, 1'b0);
        chk("t4_out_vld", out_vld, 1'b1);
        chk("t4_err_ovf", err_ovf, 1'b0);
        tick();
        out_rdy = 1'b1;
        wait_idle(300);
        chk("t4_issued_total", iss - iss0, 20);

        // spurious result with nothing in flight
        tick();
        force_val = rnd_fp();
        force_res = 1'b1;
        tick();
        force_res = 1'b0;
        @(negedge clk);
        chk("t5_out_vld", out_vld, 1'b0);
        chk("t5_err_set", err_ovf, 1'b1);
        repeat (5) @(negedge clk);
        chk("t5_err_held", err_ovf, 1'b1);

        // reset in the middle of traffic
        tick();
        out_rdy = 1'b0;
        send(8, 40);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_out_vld", out_vld, 1'b0);
        chk("t6_arg_vld", arg_vld, 1'b0);
        chk("t6_err_ovf", err_ovf, 1'b0);
        chk("t6_in_rdy", in_rdy, 1'b1);
`ifdef FP_DRV_STATS_EN
        chk("t6_issued_cnt", issued_cnt, 32'd0);
        chk("t6_retired_cnt", retired_cnt, 32'd0);
`endif

        // random traffic with a toggling consumer
        tick();
        fork
            send(24, 400);
            begin
                repeat (60) begin
                    tick();
                    out_rdy = 1'($urandom_range(0, 1));
                end
                out_rdy = 1'b1;
            end
        join
        wait_idle(400);
        chk("t7_err_ovf", err_ovf, 1'b0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
